// File: rtl/ldm_stm_sequencer_if.sv
// Decode-stage request and execute-stage micro-op bundle for the LDM/STM sequencer.
// master = pipeline side driving the request; slave = the sequencer.
interface ldm_stm_sequencer_if;
   logic        StartD;
   logic [31:0] InstrD;
   logic        HoldIn;
   logic        FlushIn;
   logic        SeqStallF;
   logic        SeqStallD;
   logic        SeqFlushE;
   logic        UopValid;
   logic [3:0]  UopRd;
   logic [3:0]  UopRn;
   logic [31:0] UopOffset;
   logic        UopLoad;
   logic        UopWB;
   logic [31:0] UopWbOffset;
   logic        UopLast;

   // No back-pressure handshake: UopValid qualifies the micro-op fields for exactly
   // one cycle unless HoldIn is high, in which case every output stays frozen.
   modport master (
      output StartD, InstrD, HoldIn, FlushIn,
      input  SeqStallF, SeqStallD, SeqFlushE, UopValid, UopRd, UopRn,
             UopOffset, UopLoad, UopWB, UopWbOffset, UopLast
   );

   modport slave (
      input  StartD, InstrD, HoldIn, FlushIn,
      output SeqStallF, SeqStallD, SeqFlushE, UopValid, UopRd, UopRn,
             UopOffset, UopLoad, UopWB, UopWbOffset, UopLast
   );
endinterface

// File: rtl/ldm_stm_sequencer.sv
// Expands an LDM/STM in decode into one registered single-register micro-op per cycle.
// Define LDM_WB_MERGE_EN to fold base writeback into the final transfer (no WB state).
module ldm_stm_sequencer #(
   parameter int NREGS = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   ldm_stm_sequencer_if.slave   bus,
   output logic [1:0]           dbg_state_o
);

   localparam int CW = $clog2(NREGS + 1);
   localparam int IW = $clog2(NREGS);
`ifdef LDM_WB_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_WB = 2'd2} state_e;

   state_e            state_q, state_d;
   logic [NREGS-1:0]  mask_q, mask_d;
   logic [CW-1:0]     k_q, k_d;
   logic [CW-1:0]     n_q, n_d;
   logic              p_q, p_d, u_q, u_d, l_q, l_d, wbreq_q, wbreq_d;
   logic [3:0]        rn_q, rn_d;

   logic              valid_q, valid_d;
   logic [IW-1:0]     rd_q, rd_d;
   logic [31:0]       off_q, off_d;
   logic              load_q, load_d;
   logic              wb_q, wb_d;
   logic [31:0]       wboff_q, wboff_d;
   logic              last_q, last_d;
   logic [3:0]        urn_q, urn_d;

   function automatic logic [CW-1:0] popcount(input logic [NREGS-1:0] v);
      logic [CW-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < NREGS; i++) cnt = cnt + CW'(v[i]);
      return cnt;
   endfunction

   function automatic logic [IW-1:0] lowest(input logic [NREGS-1:0] v);
      logic [IW-1:0] idx;
      idx = '0;
      for (int i = NREGS - 1; i >= 0; i--) if (v[i]) idx = IW'(i);
      return idx;
   endfunction

   logic [NREGS-1:0] list;
   logic             idle, start, issue_en, last_issue;
   logic [NREGS-1:0] cur_src, rest;
   logic [CW-1:0]    cur_k, cur_n;
   logic             cur_p, cur_u, cur_l, cur_wbreq;
   logic [3:0]       cur_rn;
   logic [31:0]      n4, issue_off, wb_off;
   logic             unused_instr;

   assign list         = bus.InstrD[NREGS-1:0];
   assign unused_instr = ^{bus.InstrD[31:25], bus.InstrD[22]};
   assign idle         = (state_q == S_IDLE);
   assign start        = idle & bus.StartD & (|list) & ~bus.HoldIn & ~bus.FlushIn;

   // In IDLE the first micro-op is built straight from the decode instruction,
   // afterwards from the latched fields, so one issue path serves both.
   always_comb begin
      cur_src   = idle ? list : mask_q;
      cur_k     = idle ? '0 : k_q;
      cur_n     = idle ? popcount(list) : n_q;
      cur_p     = idle ? bus.InstrD[24] : p_q;
      cur_u     = idle ? bus.InstrD[23] : u_q;
      cur_l     = idle ? bus.InstrD[20] : l_q;
      cur_rn    = idle ? bus.InstrD[19:16] : rn_q;
      cur_wbreq = idle ? (bus.InstrD[21] & ~(bus.InstrD[20] & list[bus.InstrD[19:16]]))
                       : wbreq_q;
      rest       = cur_src & (cur_src - NREGS'(1));
      last_issue = (rest == '0);
      n4         = 32'(cur_n) << 2;
      issue_off  = (32'(cur_k) << 2) + (cur_u ? 32'd0 : -n4) + ((cur_p == cur_u) ? 32'd4 : 32'd0);
      wb_off     = cur_u ? n4 : -n4;
      issue_en   = start | ((state_q == S_RUN) & (|mask_q));
   end

   always_comb begin
      state_d = state_q;  mask_d = mask_q;  k_d = k_q;  n_d = n_q;
      p_d = p_q;  u_d = u_q;  l_d = l_q;  rn_d = rn_q;  wbreq_d = wbreq_q;
      valid_d = valid_q;  rd_d = rd_q;  off_d = off_q;  load_d = load_q;
      wb_d = wb_q;  wboff_d = wboff_q;  last_d = last_q;  urn_d = urn_q;

      if (bus.FlushIn || (!bus.HoldIn && !issue_en && !idle &&
                          !(state_q == S_RUN && wbreq_q && !MERGE))) begin
         state_d = S_IDLE;  mask_d = '0;  k_d = '0;
         valid_d = 1'b0;  rd_d = '0;  off_d = '0;  load_d = 1'b0;
         wb_d = 1'b0;  wboff_d = '0;  last_d = 1'b0;  urn_d = '0;
      end else if (!bus.HoldIn && issue_en) begin
         state_d = S_RUN;   mask_d = rest;   k_d = cur_k + CW'(1);  n_d = cur_n;
         p_d = cur_p;  u_d = cur_u;  l_d = cur_l;  rn_d = cur_rn;  wbreq_d = cur_wbreq;
         valid_d = 1'b1;  rd_d = lowest(cur_src);  off_d = issue_off;  load_d = cur_l;
         wboff_d = wb_off;  urn_d = cur_rn;
         last_d  = last_issue & (MERGE | ~cur_wbreq);
         wb_d    = MERGE & last_issue & cur_wbreq;
      end else if (!bus.HoldIn && state_q == S_RUN && wbreq_q && !MERGE) begin
         // Writeback-only micro-op: no memory transfer, zero address offset.
         state_d = S_WB;
         valid_d = 1'b1;  rd_d = IW'(rn_q);  off_d = '0;  load_d = 1'b0;
         wb_d = 1'b1;  last_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;  mask_q <= '0;  k_q <= '0;  n_q <= '0;
         p_q <= 1'b0;  u_q <= 1'b0;  l_q <= 1'b0;  rn_q <= '0;  wbreq_q <= 1'b0;
         valid_q <= 1'b0;  rd_q <= '0;  off_q <= '0;  load_q <= 1'b0;
         wb_q <= 1'b0;  wboff_q <= '0;  last_q <= 1'b0;  urn_q <= '0;
      end else begin
         state_q <= state_d;  mask_q <= mask_d;  k_q <= k_d;  n_q <= n_d;
         p_q <= p_d;  u_q <= u_d;  l_q <= l_d;  rn_q <= rn_d;  wbreq_q <= wbreq_d;
         valid_q <= valid_d;  rd_q <= rd_d;  off_q <= off_d;  load_q <= load_d;
         wb_q <= wb_d;  wboff_q <= wboff_d;  last_q <= last_d;  urn_q <= urn_d;
      end
   end

   // Decode may advance only at the edge that retires the final micro-op.
   assign bus.SeqStallF   = start | (~idle & ~(valid_q & last_q & ~bus.HoldIn));
   assign bus.SeqStallD   = bus.SeqStallF;
   assign bus.SeqFlushE   = start | ~idle;
   assign bus.UopValid    = valid_q;
   assign bus.UopRd       = rd_q;
   assign bus.UopRn       = urn_q;
   assign bus.UopOffset   = off_q;
   assign bus.UopLoad     = load_q;
   assign bus.UopWB       = wb_q;
   assign bus.UopWbOffset = wboff_q;
   assign bus.UopLast     = last_q;
   assign dbg_state_o     = state_q;

endmodule
